coef_stream_sched: RTL
======================

Name: coef_stream_sched

Overview:
- Scheduler that shares one downstream coefficient port between two stream generators.
- The Sq coefficient generator supplies 13-bit coefficients. The ternary-lift generator supplies 4-bit chunks.
- The block latches stream requests, grants them round-robin, pulses the chosen generator's load, and meters each coefficient through a valid/ready handshake. Each generator advances only on an accepted beat.
- It sits between the poly/lift generators and the multiplier front end in the Sq multiplication path.

Parameters:
- SQ_W, 13, Sq coefficient width; also the output data width.
- SQ_LEN, 701, number of beats in a Sq stream.
- TN_W, 4, ternary chunk width; must be ≤ SQ_W.
- TN_LEN, 350, number of beats in a ternary stream.
- CNT_W, 10, counter width; must satisfy 2^CNT_W > max(SQ_LEN, TN_LEN).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_sq  in  1  one-cycle pulse requesting a Sq stream.
- req_tn  in  1  one-cycle pulse requesting a ternary stream.
- sq_data  in  SQ_W  current coefficient from the Sq generator.
- tn_data  in  TN_W  current chunk from the ternary generator.
- load_sq  out  1  load strobe to the Sq generator (its en).
- adv_sq  out  1  shift/advance strobe to the Sq generator.
- load_tn  out  1  load strobe to the ternary generator.
- adv_tn  out  1  shift/advance strobe to the ternary generator.
- out_data  out  SQ_W  streamed beat; tn_data is zero-extended.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts the beat.
- out_src  out  1  0 = Sq stream, 1 = ternary stream.
- out_last  out  1  final beat of the current stream.
- busy  out  1  a stream is in progress (LOAD or STREAM).
- done_sq  out  1  one-cycle pulse when a Sq stream completes.
- done_tn  out  1  one-cycle pulse when a ternary stream completes.

Behaviour:
- Reset (async, rst=1):
  - State = IDLE; pend_sq, pend_tn and cnt cleared; last_grant = 1 (tn), so Sq wins the first tie.
  - All outputs 0, including out_data.
  - Reset mid-stream aborts the stream with no done pulse.
- Request latching:
  - req_x=1 sets pend_x at the clock edge in any state.
  - pend_x clears only on the edge that grants channel x.
  - A req_x arriving on that same edge wins: pend_x stays 1.
  - Repeated pulses while already pending collapse into one request.
- IDLE:
  - No pending request: stay in IDLE.
  - One pending request: grant it.
  - Both pending: grant the channel ≠ last_grant.
  - On a grant: record src and last_grant, clear cnt, go to LOAD.
- LOAD (exactly 1 cycle):
  - load_src = 1. out_valid = 0, busy = 1.
  - Next state STREAM. The generator output is valid from the next cycle.
- STREAM:
  - out_valid = 1 and busy = 1.
  - out_data = sq_data when src=0; {zeros, tn_data} when src=1. This path is combinational.
  - Accept = out_valid & out_ready.
  - adv_src = accept, combinational, so the generator shifts on the same edge.
  - On accept: cnt++.
  - out_last = (cnt == LEN_src − 1).
  - Accept while out_last: go to DONE, no cnt wrap.
  - out_ready=0: hold state, cnt and data. No adv, no timeout.
- DONE (1 cycle):
  - done_src = 1, busy = 0, out_valid = 0.
  - Next state IDLE. A pending request is granted from IDLE on the following cycle.
- Strobe rules:
  - load_* and adv_* are never asserted together.
  - Only the granted channel's strobes are ever asserted.
- Ideal timing:
  - With out_ready tied high, one stream occupies 1 + LEN + 1 cycles from grant to done.
  - IDLE adds one extra cycle between back-to-back streams.

Test Plan:
- Single Sq stream: req_sq pulse, out_ready=1, generator fed index-valued coefficients → load_sq 1 cycle, then 701 beats 0..700, out_last on beat 700, adv_sq high 701 cycles, done_sq one cycle, busy low afterwards.
- Single ternary stream: req_tn, out_ready=1 → out_src=1, 350 beats with out_data[12:4]=0, out_last on beat 349, done_tn pulse.
- Simultaneous req_sq and req_tn from reset → Sq stream first, ternary stream second, no beat lost. Repeat both requests → order alternates by last_grant.
- Backpressure: random out_ready ~50% on a Sq stream → exactly 701 accepted beats in order; adv_sq count = 701; out_data stable while out_ready=0.
- Request during stream: req_sq pulse mid ternary stream, plus a second req_tn pulse → Sq stream follows; ternary stream is granted again afterwards, exactly once.
- Reset at beat 100 of a Sq stream → all outputs 0 immediately, no done_sq. A fresh req_sq then yields a full 701-beat stream.

Source files
------------

// File: rtl/coef_stream_sched.sv
// Round-robin scheduler sharing one coefficient output port between the Sq
// generator and the ternary-lift generator; beats metered by valid/ready.
module coef_stream_sched #(
  parameter int SQ_W   = 13,
  parameter int SQ_LEN = 701,
  parameter int TN_W   = 4,
  parameter int TN_LEN = 350,
  parameter int CNT_W  = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_sq,
  input  logic            req_tn,
  input  logic [SQ_W-1:0] sq_data,
  input  logic [TN_W-1:0] tn_data,
  output logic            load_sq,
  output logic            adv_sq,
  output logic            load_tn,
  output logic            adv_tn,
  output logic [SQ_W-1:0] out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_src,
  output logic            out_last,
  output logic            busy,
  output logic            done_sq,
  output logic            done_tn
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [CNT_W-1:0] SQ_LAST = CNT_W'(SQ_LEN - 1);
  localparam logic [CNT_W-1:0] TN_LAST = CNT_W'(TN_LEN - 1);

  logic [1:0]       state_q, state_d;
  logic             pend_sq_q, pend_sq_d;
  logic             pend_tn_q, pend_tn_d;
  logic             last_grant_q, last_grant_d;
  logic             src_q, src_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic in_load, in_stream, in_done;
  logic grant_any, grant_src, grant_sq, grant_tn;
  logic beat_last, accept;

  assign in_load   = (state_q == S_LOAD);
  assign in_stream = (state_q == S_STREAM);
  assign in_done   = (state_q == S_DONE);

  // With both pending the channel not granted last time wins; otherwise the
  // lone pending channel wins (pend_tn alone selects 1, pend_sq alone 0).
  assign grant_any = (state_q == S_IDLE) && (pend_sq_q || pend_tn_q);
  assign grant_src = (pend_sq_q && pend_tn_q) ? ~last_grant_q : pend_tn_q;
  assign grant_sq  = grant_any && !grant_src;
  assign grant_tn  = grant_any && grant_src;

  assign beat_last = in_stream && (cnt_q == (src_q ? TN_LAST : SQ_LAST));
  assign accept    = in_stream && out_ready;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    src_d        = src_q;
    cnt_d        = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (grant_any) begin
          state_d      = S_LOAD;
          src_d        = grant_src;
          last_grant_d = grant_src;
          cnt_d        = '0;
        end
      end
      S_LOAD:   state_d = S_STREAM;
      S_STREAM: begin
        if (accept) begin
          if (beat_last) state_d = S_DONE;
          else           cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default:  state_d = S_IDLE;
    endcase
  end

  // A request on the granting edge re-arms the flag it would have cleared.
  assign pend_sq_d = req_sq || (pend_sq_q && !grant_sq);
  assign pend_tn_d = req_tn || (pend_tn_q && !grant_tn);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pend_sq_q    <= 1'b0;
      pend_tn_q    <= 1'b0;
      last_grant_q <= 1'b1;
      src_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      pend_sq_q    <= pend_sq_d;
      pend_tn_q    <= pend_tn_d;
      last_grant_q <= last_grant_d;
      src_q        <= src_d;
      cnt_q        <= cnt_d;
    end
  end

  assign load_sq   = in_load && !src_q;
  assign load_tn   = in_load && src_q;
  assign adv_sq    = accept && !src_q;
  assign adv_tn    = accept && src_q;
  assign out_valid = in_stream;
  assign out_src   = (in_load || in_stream || in_done) && src_q;
  assign out_last  = beat_last;
  assign busy      = in_load || in_stream;
  assign done_sq   = in_done && !src_q;
  assign done_tn   = in_done && src_q;
  assign out_data  = !in_stream ? '0 : (src_q ? SQ_W'(tn_data) : sq_data);

endmodule
